// File: rtl/servo_pwm.sv
// -----------------------------------------------------------------------------
// servo_pwm
//
// Purpose:
//   Fixed-period servo pulse generator. A prescaler divides clk into position
//   steps; a step counter spans one frame of PERIOD_STEPS steps. The output
//   pulse is high for BASE_STEPS + position steps at the start of each frame.
//   Position and enable are captured into shadow registers only at the frame
//   boundary, so a pulse already in flight is never shortened or stretched.
//   A one-cycle frame_start strobe marks each frame for upstream sequencers.
//
// Optional feature (compile-time macro):
//   SERVO_PWM_LIMIT_EN - when defined, the requested position is clamped to
//                        [MIN_POS, MAX_POS] before it is captured. When not
//                        defined, MIN_POS/MAX_POS only take part in the
//                        elaboration-time parameter checks.
//
// Ports:
//   clk         in   1  system clock
//   rst         in   1  asynchronous, active-high reset
//   pos         in   8  requested position, unsigned, captured at frame boundary
//   ena         in   1  output enable, captured at frame boundary
//   servo       out  1  registered PWM output
//   frame_start out  1  registered one-cycle strobe, one clock after boundary
//   cur_pos     out  8  position currently being played (shadow register)
// -----------------------------------------------------------------------------
module servo_pwm #(
  parameter int STEP_CYCLES  = 47,
  parameter int BASE_STEPS   = 256,
  parameter int PERIOD_STEPS = 5106,
  parameter int MIN_POS      = 0,
  parameter int MAX_POS      = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] pos,
  input  logic       ena,
  output logic       servo,
  output logic       frame_start,
  output logic [7:0] cur_pos
);

  // Elaboration-time sanity checks on the configuration.
  if (STEP_CYCLES < 1) begin : g_bad_step
    $error("servo_pwm: STEP_CYCLES must be >= 1");
  end
  if (PERIOD_STEPS < BASE_STEPS + 256) begin : g_bad_period
    $error("servo_pwm: PERIOD_STEPS must be >= BASE_STEPS + 256");
  end
  if (MIN_POS > MAX_POS || MIN_POS < 0 || MAX_POS > 255) begin : g_bad_limits
    $error("servo_pwm: need 0 <= MIN_POS <= MAX_POS <= 255");
  end

  localparam int PRE_W  = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int STEP_W = (PERIOD_STEPS > 1) ? $clog2(PERIOD_STEPS) : 1;
  // Compare width: one bit of headroom over the step counter and never
  // narrower than 10 bits, so BASE_STEPS + 255 cannot wrap.
  localparam int CMP_W  = (STEP_W + 1 > 10) ? STEP_W + 1 : 10;

  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(STEP_CYCLES - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(PERIOD_STEPS - 1);
  localparam logic [CMP_W-1:0]  BASE_CMP  = CMP_W'(BASE_STEPS);

  logic [PRE_W-1:0]  pre_cnt;
  logic [STEP_W-1:0] step_cnt;
  logic [7:0]        shadow;
  logic              ena_sh;

  logic              step_tick;
  logic              fb;
  logic [7:0]        pos_eff;
  logic [7:0]        eff_pos;
  logic              eff_ena;
  logic [CMP_W-1:0]  step_ext;
  logic [CMP_W-1:0]  pulse_end;
  logic              servo_nxt;

`ifdef SERVO_PWM_LIMIT_EN
  localparam logic [7:0] MIN_P = 8'(MIN_POS);
  localparam logic [7:0] MAX_P = 8'(MAX_POS);

  always_comb begin
    pos_eff = pos;
    if (pos < MIN_P) begin
      pos_eff = MIN_P;
    end else if (pos > MAX_P) begin
      pos_eff = MAX_P;
    end
  end
`else
  assign pos_eff = pos;
`endif

  assign step_tick = (pre_cnt == PRE_LAST);
  assign fb        = (pre_cnt == '0) && (step_cnt == '0);

  // In the boundary cycle the freshly requested values drive the compare, so
  // the first pulse cycle of a frame already reflects what is being captured.
  assign eff_pos = fb ? pos_eff : shadow;
  assign eff_ena = fb ? ena     : ena_sh;

  assign step_ext  = {{(CMP_W - STEP_W){1'b0}}, step_cnt};
  assign pulse_end = BASE_CMP + CMP_W'(eff_pos);
  assign servo_nxt = eff_ena && (step_ext < pulse_end);

  // Prescaler and frame step counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt  <= '0;
      step_cnt <= '0;
    end else begin
      if (step_tick) begin
        pre_cnt <= '0;
        if (step_cnt == STEP_LAST) begin
          step_cnt <= '0;
        end else begin
          step_cnt <= step_cnt + 1'b1;
        end
      end else begin
        pre_cnt <= pre_cnt + 1'b1;
      end
    end
  end

  // Shadow registers: updated only at the frame boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow <= '0;
      ena_sh <= 1'b0;
    end else if (fb) begin
      shadow <= pos_eff;
      ena_sh <= ena;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      servo       <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      servo       <= servo_nxt;
      frame_start <= fb;
    end
  end

  assign cur_pos = shadow;

endmodule

// File: tb/tb_servo_pwm.sv
module tb_servo_pwm;

  localparam int STEP_CYCLES  = 2;
  localparam int BASE_STEPS   = 4;
  localparam int PERIOD_STEPS = 300;
  localparam int PERIOD_CYC   = 600;
  localparam int LIMIT        = 2000;

  logic       clk;
  logic       rst;
  logic [7:0] pos;
  logic       ena;
  logic       servo;
  logic       frame_start;
  logic [7:0] cur_pos;

  int errors = 0;
  int checks = 0;

  servo_pwm #(
    .STEP_CYCLES (STEP_CYCLES),
    .BASE_STEPS  (BASE_STEPS),
    .PERIOD_STEPS(PERIOD_STEPS),
    .MIN_POS     (20),
    .MAX_POS     (200)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pos        (pos),
    .ena        (ena),
    .servo      (servo),
    .frame_start(frame_start),
    .cur_pos    (cur_pos)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Waits (bounded) for a negedge where frame_start is high.
  task automatic wait_fs(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < LIMIT && !ok; i++) begin
      @(negedge clk);
      if (frame_start === 1'b1) ok = 1'b1;
    end
  endtask

  // Called on the negedge where frame_start is high (index 0). Counts servo
  // high cycles and frame length until the next frame_start negedge, where it
  // returns. At index chg_at the inputs are changed before sampling; index
  // PERIOD_CYC-1 is the boundary cycle of the next frame.
  task automatic measure(input int chg_at, input logic [7:0] chg_pos,
                         input logic chg_ena, output int high, output int period);
    high   = 0;
    period = 0;
    do begin
      if (period == chg_at) begin
        pos = chg_pos;
        ena = chg_ena;
      end
      if (servo === 1'b1) high++;
      period++;
      @(negedge clk);
    end while (frame_start !== 1'b1 && period < LIMIT);
  endtask

  task automatic test_reset();
    bit ok;
    int h, p;
    rst = 1'b1;
    pos = 8'd0;
    ena = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (servo !== 1'b0 || frame_start !== 1'b0 || cur_pos !== 8'd0) begin
      errors++;
      $display("FAIL reset_state: servo=%b fs=%b cur_pos=%0d, required 0/0/0",
               servo, frame_start, cur_pos);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (frame_start !== 1'b1 || servo !== 1'b1) begin
      errors++;
      $display("FAIL first_frame_cycle1: fs=%b servo=%b, required 1/1", frame_start, servo);
    end
    wait_fs(ok);
    measure(-1, 8'd0, 1'b1, h, p);
    checks++;
    if (h !== 8 || p !== PERIOD_CYC) begin
      errors++;
      $display("FAIL pos0_frame: high=%0d period=%0d, required 8/600", h, p);
    end
  endtask

  task automatic test_positions();
    int h, p;
    measure(10, 8'd10, 1'b1, h, p);
    measure(-1, 8'd10, 1'b1, h, p);
    checks++;
    if (h !== 28 || p !== PERIOD_CYC || cur_pos !== 8'd10) begin
      errors++;
      $display("FAIL pos10: high=%0d period=%0d cur_pos=%0d, required 28/600/10", h, p, cur_pos);
    end
    measure(10, 8'd255, 1'b1, h, p);
    measure(-1, 8'd255, 1'b1, h, p);
    checks++;
    if (h !== 518 || p !== PERIOD_CYC) begin
      errors++;
      $display("FAIL pos255: high=%0d period=%0d, required 518/600", h, p);
    end
    checks++;
    if (cur_pos !== 8'd255) begin
      errors++;
      $display("FAIL pos255_cur: cur_pos=%0d, required 255", cur_pos);
    end
  endtask

  task automatic test_midframe();
    int h, p;
    measure(10, 8'd10, 1'b1, h, p);          // 255-frame, arms pos=10
    measure(5, 8'd50, 1'b1, h, p);           // change mid-pulse
    checks++;
    if (h !== 28) begin
      errors++;
      $display("FAIL midpulse_change_current: high=%0d, required 28", h);
    end
    measure(PERIOD_CYC - 1, 8'd10, 1'b1, h, p); // change in boundary cycle
    checks++;
    if (h !== 108 || p !== PERIOD_CYC) begin
      errors++;
      $display("FAIL midpulse_change_next: high=%0d period=%0d, required 108/600", h, p);
    end
    measure(0, 8'd50, 1'b1, h, p);           // one cycle after boundary
    checks++;
    if (h !== 28) begin
      errors++;
      $display("FAIL change_at_fb: high=%0d, required 28", h);
    end
    measure(-1, 8'd50, 1'b1, h, p);
    checks++;
    if (h !== 108) begin
      errors++;
      $display("FAIL change_after_fb: high=%0d, required 108", h);
    end
  endtask

  task automatic test_enable();
    int h, p;
    measure(100, 8'd50, 1'b0, h, p);
    checks++;
    if (h !== 108) begin
      errors++;
      $display("FAIL ena_off_midframe: high=%0d, required 108", h);
    end
    measure(3, 8'd50, 1'b1, h, p);
    checks++;
    if (h !== 0 || p !== PERIOD_CYC) begin
      errors++;
      $display("FAIL ena_off_frame: high=%0d period=%0d, required 0/600", h, p);
    end
    measure(-1, 8'd50, 1'b1, h, p);
    checks++;
    if (h !== 108) begin
      errors++;
      $display("FAIL ena_back_on: high=%0d, required 108", h);
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    int h, p;
    // Currently at a frame_start negedge with servo high.
    #1 rst = 1'b1;
    #1;
    checks++;
    if (servo !== 1'b0 || frame_start !== 1'b0 || cur_pos !== 8'd0) begin
      errors++;
      $display("FAIL async_reset: servo=%b fs=%b cur_pos=%0d, required 0/0/0",
               servo, frame_start, cur_pos);
    end
    @(negedge clk);
    rst = 1'b0;
    wait_fs(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL restart_timeout: no frame_start after reset, required one");
    end
    measure(-1, 8'd50, 1'b1, h, p);
    checks++;
    if (h !== 108 || p !== PERIOD_CYC) begin
      errors++;
      $display("FAIL restart_frame: high=%0d period=%0d, required 108/600", h, p);
    end
  endtask

  task automatic test_limits();
    int h, p;
    int exp_lo_h, exp_hi_h;
    logic [7:0] exp_lo_c, exp_hi_c;
`ifdef SERVO_PWM_LIMIT_EN
    exp_lo_h = 48;  exp_lo_c = 8'd20;
    exp_hi_h = 408; exp_hi_c = 8'd200;
`else
    exp_lo_h = 18;  exp_lo_c = 8'd5;
    exp_hi_h = 508; exp_hi_c = 8'd250;
`endif
    measure(0, 8'd5, 1'b1, h, p);
    measure(-1, 8'd5, 1'b1, h, p);
    checks++;
    if (h !== exp_lo_h || cur_pos !== exp_lo_c) begin
      errors++;
      $display("FAIL limit_low: high=%0d cur_pos=%0d, required %0d/%0d",
               h, cur_pos, exp_lo_h, exp_lo_c);
    end
    measure(0, 8'd250, 1'b1, h, p);
    measure(-1, 8'd250, 1'b1, h, p);
    checks++;
    if (h !== exp_hi_h || cur_pos !== exp_hi_c || p !== PERIOD_CYC) begin
      errors++;
      $display("FAIL limit_high: high=%0d cur_pos=%0d period=%0d, required %0d/%0d/600",
               h, cur_pos, p, exp_hi_h, exp_hi_c);
    end
  endtask

  initial begin
    test_reset();
    test_positions();
    test_midframe();
    test_enable();
    test_async_reset();
    test_limits();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
